fpu_operand_loader: RTL and testbench

Upstream input stage for the six-operand floating-point adder. Accepts a byte stream from the 8-bit pad interface, assembles six IEEE-754 single-precision operands, flags special encodings, and presents a complete operand frame to the adder through a valid/ready handshake. A double-buffered design (assembly register plus output register) lets the next frame be collected while the adder still holds the current one.

---
 rtl/fpu_operand_loader.sv | 120 ++++++++++++
 tb/tb_fpu_operand_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_operand_loader.sv
// rtl/fpu_operand_loader.sv - byte stream to six-operand FP frame loader with double buffering
module fpu_operand_loader #(
    parameter int NUM_OPS  = 6,
    parameter int OP_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  byte_in,
    input  logic                        byte_valid,
    input  logic                        byte_sof,
    output logic                        byte_ready,
    output logic [NUM_OPS*OP_WIDTH-1:0] ops_out,
    output logic [NUM_OPS-1:0]          special_flags,
    output logic                        ops_valid,
    input  logic                        ops_ready,
    output logic                        frame_err
);

    localparam int FRAME_W     = NUM_OPS * OP_WIDTH;
    localparam int FRAME_BYTES = FRAME_W / 8;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     byte_idx_q;
    logic [FRAME_W-1:0]   asm_q;
    logic [FRAME_W-1:0]   asm_d;
    logic [FRAME_W-1:0]   ops_q;
    logic [NUM_OPS-1:0]   flags_q;
    logic [NUM_OPS-1:0]   flags_d;
    logic                 valid_q;
    logic                 frame_err_q;

    logic                 accept;
    logic                 early_sof;
    logic                 last_byte;
    logic                 slot_free;
    logic                 load_out;
    logic [IDX_W-1:0]     wr_idx;
    logic [7:0]           exp_f;
    logic [22:0]          mant_f;

    assign byte_ready    = (state_q != S_FULL);
    assign ops_out       = ops_q;
    assign special_flags = flags_q;
    assign ops_valid     = valid_q;
    assign frame_err     = frame_err_q;

    always_comb begin
        accept    = byte_valid && byte_ready;
        early_sof = accept && byte_sof && (byte_idx_q != '0);
        // An early sof restarts the frame: its byte lands in slot 0.
        wr_idx    = early_sof ? '0 : byte_idx_q;
        last_byte = accept && !early_sof && (byte_idx_q == LAST_IDX);
        slot_free = !valid_q || ops_ready;
        load_out  = slot_free && (last_byte || (state_q == S_FULL));

        asm_d = asm_q;
        if (accept) begin
            asm_d[{wr_idx, 3'b000} +: 8] = byte_in;
        end

        flags_d = '0;
        exp_f   = '0;
        mant_f  = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            exp_f      = asm_d[k*OP_WIDTH + 23 +: 8];
            mant_f     = asm_d[k*OP_WIDTH +: 23];
            flags_d[k] = (exp_f == 8'hFF) || ((exp_f == 8'h00) && (mant_f != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            ops_q       <= '0;
            flags_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            frame_err_q <= early_sof;

            if (accept) begin
                byte_idx_q <= last_byte ? '0 : wr_idx + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) state_q <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (last_byte) state_q <= slot_free ? S_IDLE : S_FULL;
                end
                S_FULL: begin
                    if (slot_free) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // A transfer on the consuming edge keeps valid high with no bubble.
            if (load_out) begin
                ops_q   <= asm_d;
                flags_q <= flags_d;
                valid_q <= 1'b1;
            end else if (ops_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// tb/tb_fpu_operand_loader.sv - scoreboard bench for fpu_operand_loader
module tb_fpu_operand_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   byte_in = '0;
    logic         byte_valid = 1'b0;
    logic         byte_sof = 1'b0;
    logic         byte_ready;
    logic [191:0] ops_out;
    logic [5:0]   special_flags;
    logic         ops_valid;
    logic         ops_ready = 1'b0;
    logic         frame_err;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int ferr_cnt = 0;

    logic [191:0] exp_ops[$];
    logic [5:0]   exp_flags[$];
    int           hs_cyc[$];

    logic [191:0] fr_basic, fr_spec, fr_a, fr_b, fr_e;

    fpu_operand_loader #(.NUM_OPS(6), .OP_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_sof(byte_sof),
        .byte_ready(byte_ready),
        .ops_out(ops_out),
        .special_flags(special_flags),
        .ops_valid(ops_valid),
        .ops_ready(ops_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [191:0] mk(input logic [31:0] a0, input logic [31:0] a1,
                                        input logic [31:0] a2, input logic [31:0] a3,
                                        input logic [31:0] a4, input logic [31:0] a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    // Scoreboard monitor: compares every consumed frame against the queue.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (rst_n && ops_valid && ops_ready) begin
            if (exp_ops.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame: got %h expected none", ops_out);
            end else begin
                chk("frame_ops", ops_out, exp_ops.pop_front());
                chk("frame_flags", {186'b0, special_flags}, {186'b0, exp_flags.pop_front()});
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic sof);
        int  waited = 0;
        bit  done = 0;
        byte_in    = b;
        byte_sof   = sof;
        byte_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL send_timeout: byte_ready stuck at %b, required 1", byte_ready);
                    done = 1;
                end
            end
        end
        byte_valid = 1'b0;
        byte_sof   = 1'b0;
    endtask

    task automatic send_range(input logic [191:0] fr, input int lo, input int hi, input logic sof_first);
        for (int i = lo; i <= hi; i++) begin
            send_byte(fr[i*8 +: 8], sof_first && (i == lo));
        end
    endtask

    task automatic push_exp(input logic [191:0] fr, input logic [5:0] fl);
        exp_ops.push_back(fr);
        exp_flags.push_back(fl);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, {191'b0, byte_ready}, 192'd1);
        chk({tag, "_ops_valid"}, {191'b0, ops_valid}, 192'd0);
        chk({tag, "_ops_out"}, ops_out, 192'd0);
        chk({tag, "_flags"}, {186'b0, special_flags}, 192'd0);
        chk({tag, "_frame_err"}, {191'b0, frame_err}, 192'd0);
    endtask

    initial begin
        fr_basic = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        fr_spec  = mk(32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h00000000, 32'h80000000, 32'h40490FDB);
        fr_a     = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000);
        fr_b     = mk(32'h7F800000, 32'h3F800000, 32'h00000000, 32'h807FFFFF, 32'h42280000, 32'hFFC00000);
        fr_e     = mk(32'h400000AA, 32'h11223344, 32'h00000000, 32'hFF800000, 32'h00400000, 32'hC0000000);

        idle(3);
        rst_n = 1'b1;
        idle(1);
        check_reset_outputs("reset");

        // Basic frame and exact latency.
        ops_ready = 1'b1;
        push_exp(fr_basic, 6'b000000);
        send_range(fr_basic, 0, 22, 1'b0);
        chk("basic_not_early", {191'b0, ops_valid}, 192'd0);
        send_range(fr_basic, 23, 23, 1'b0);
        chk("basic_latency", {191'b0, ops_valid}, 192'd1);
        idle(1);
        chk("basic_valid_drop", {191'b0, ops_valid}, 192'd0);

        push_exp(fr_spec, 6'b000111);
        send_range(fr_spec, 0, 23, 1'b1);
        idle(2);

        // Backpressure: frame A held, frame B parked in FULL.
        ops_ready = 1'b0;
        push_exp(fr_a, 6'b000000);
        push_exp(fr_b, 6'b101001);
        send_range(fr_a, 0, 23, 1'b1);
        send_range(fr_b, 0, 23, 1'b1);
        chk("bp_full_ready", {191'b0, byte_ready}, 192'd0);
        idle(3);
        chk("bp_hold_valid", {191'b0, ops_valid}, 192'd1);
        chk("bp_hold_ops", ops_out, fr_a);
        chk("bp_full_ready_held", {191'b0, byte_ready}, 192'd0);
        ops_ready = 1'b1;
        idle(1);
        ops_ready = 1'b0;
        chk("bp_swap_valid", {191'b0, ops_valid}, 192'd1);
        chk("bp_swap_ops", ops_out, fr_b);
        chk("bp_swap_flags", {186'b0, special_flags}, 192'd41);
        chk("bp_ready_back", {191'b0, byte_ready}, 192'd1);
        idle(1);
        ops_ready = 1'b1;
        idle(2);

        // Early sof: 10 junk bytes, then AA with sof and the rest of frame E.
        for (int i = 0; i < 10; i++) send_byte(8'h55 + 8'(i), i == 0);
        push_exp(fr_e, 6'b011000);
        send_range(fr_e, 0, 0, 1'b1);
        chk("esof_pulse", {191'b0, frame_err}, 192'd1);
        send_range(fr_e, 1, 1, 1'b0);
        chk("esof_pulse_end", {191'b0, frame_err}, 192'd0);
        send_range(fr_e, 2, 23, 1'b0);
        idle(2);

        // Reset mid-frame.
        send_range(fr_a, 0, 11, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        push_exp(fr_basic, 6'b000000);
        send_range(fr_basic, 0, 23, 1'b0);
        idle(2);

        // Reset while in FULL.
        ops_ready = 1'b0;
        send_range(fr_a, 0, 23, 1'b1);
        send_range(fr_b, 0, 23, 1'b1);
        chk("rst_full_ready", {191'b0, byte_ready}, 192'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_full");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        ops_ready = 1'b1;
        push_exp(fr_spec, 6'b000111);
        send_range(fr_spec, 0, 23, 1'b0);
        idle(2);

        // Throughput: three back-to-back frames.
        hs_cyc.delete();
        push_exp(fr_a, 6'b000000);
        push_exp(fr_b, 6'b101001);
        push_exp(fr_e, 6'b011000);
        send_range(fr_a, 0, 23, 1'b1);
        send_range(fr_b, 0, 23, 1'b0);
        send_range(fr_e, 0, 23, 1'b1);
        idle(3);
        chk("tp_count", 192'(hs_cyc.size()), 192'd3);
        if (hs_cyc.size() == 3) begin
            chk("tp_gap1", 192'(hs_cyc[1] - hs_cyc[0]), 192'd24);
            chk("tp_gap2", 192'(hs_cyc[2] - hs_cyc[1]), 192'd24);
        end

        idle(5);
        chk("sb_drained", 192'(exp_ops.size()), 192'd0);
        chk("frame_err_total", 192'(ferr_cnt), 192'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
